// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the KLP32 data-memory port.
// Imported by the responder, its storage array and the core-side master.
package klp32_mem_pkg;

   localparam int unsigned BE_W   = 4;
   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   typedef struct packed {
      logic              we;
      logic [31:0]       addr;
      logic [BE_W-1:0]   be;
      logic [WORD_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the KLP32 core (master) and the data-memory responder (slave).
interface dmem_responder_if;

   logic                               req_valid;
   logic                               req_ready;
   logic                               req_we;
   logic [31:0]                        req_addr;
   logic [klp32_mem_pkg::BE_W-1:0]     req_be;
   logic [klp32_mem_pkg::WORD_W-1:0]   req_wdata;
   logic                               rsp_valid;
   logic                               rsp_ready;
   logic [klp32_mem_pkg::WORD_W-1:0]   rsp_rdata;
   logic                               rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage with one byte-lane-masked write port and one asynchronous read port.
// Contents are deliberately not reset.
module dmem_array
   import klp32_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
   input  logic [BE_W-1:0]                wbe,
   input  logic [WORD_W-1:0]              wdata,
   input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
   output logic [WORD_W-1:0]              rdata
);

   logic [WORD_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < BE_W; i++) begin
            if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Latency-configurable data-memory responder: one outstanding request, fault check,
// store commit and load capture on the edge entering RESP.
module dmem_responder
   import klp32_mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   state_t            state, state_nx;
   logic [3:0]        cnt;
   req_t              live, cap, cur;
   logic              ready, valid, enter_resp, fault;
   logic [AW-1:0]     idx;
   logic [WORD_W-1:0] arr_rdata, rdata_q;
   logic              err_q;

   assign live = '{we: bus.req_we, addr: bus.req_addr, be: bus.req_be, wdata: bus.req_wdata};

   // With LATENCY==1 the request is evaluated on its own accept edge, so IDLE uses the live bus.
   assign cur   = (state == IDLE) ? live : cap;
   assign fault = (cur.addr[1:0] != 2'b00) || ({2'b00, cur.addr[31:2]} >= 32'(DEPTH_WORDS));
   assign idx   = cur.addr[AW+1:2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ready    = 1'b0;
      valid    = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.req_valid) state_nx = (LATENCY == 1) ? RESP : WAIT;
         end
         WAIT: if (cnt == 4'd1) state_nx = RESP;
         RESP: begin
            valid = 1'b1;
            if (bus.rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign enter_resp = (state != RESP) && (state_nx == RESP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap     <= '0;
         cnt     <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (bus.req_valid && ready) begin
            cap <= live;
            cnt <= 4'(LATENCY - 1);
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            err_q   <= fault;
            rdata_q <= (fault || cur.we) ? '0 : arr_rdata;
         end
      end
   end

   dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
      .clk   (clk),
      .we    (enter_resp && !fault && cur.we),
      .waddr (idx),
      .wbe   (cur.be),
      .wdata (cur.wdata),
      .raddr (idx),
      .rdata (arr_rdata)
   );

   assign bus.req_ready = ready;
   assign bus.rsp_valid = valid;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Latency-configurable data-memory responder for the KLP32 core's load/store port. It is the memory-side end of the data interface: it accepts one request at a time over a valid/ready handshake, performs a byte-lane-masked write or a full-word read after a programmable number of wait states, and returns a response over a second valid/ready handshake. It replaces the zero-latency data memory when the core is moved to a stallable memory interface.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words of storage; must be a power of two.
- LATENCY, 2: cycles from request acceptance to response valid; legal range 1..15.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; the block is in reset while reset==0.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_be  input  4  byte enables for stores; bit i selects wdata[8i+7:8i]; ignored on loads.
- req_wdata  input  32  store data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load data: the full aligned word. Store responses return 0.
- rsp_err  output  1  access fault (misaligned or out of range).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/be/wdata, load the wait counter with LATENCY-1, and go to WAIT. If LATENCY==1, go directly to RESP.
- WAIT: req_ready=0. Decrement the counter each cycle. When the counter is 1, go to RESP on the next edge.
- On the edge entering RESP, evaluate the captured request:
  - Error if addr[1:0]!=0, or if word index addr[31:2] >= DEPTH_WORDS.
  - Error: no write; rdata=0; err=1.
  - Valid store: write only the enabled byte lanes; rdata=0; err=0. A store with be=0 completes as a no-op with err=0.
  - Valid load: rdata = mem[addr[31:2]]; err=0.
- RESP: rsp_valid=1, with rdata and err held stable until rsp_ready=1. On rsp_valid&&rsp_ready, go to IDLE.
- Only one request is outstanding at a time. There is no same-cycle response-to-request overlap; req_ready rises the cycle after the response handshake.
- Storage contents are not cleared by reset; their power-up value is X.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Request accepted at edge N produces rsp_valid=1 from the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Response handshake at edge M: rsp_valid=0 and req_ready=1 in the cycle after M. Minimum issue interval is LATENCY+1 cycles with rsp_ready tied high.
- rsp_ready low holds RESP indefinitely. Outputs must not change while held.
- req_valid while req_ready=0 is ignored. Request inputs are sampled only at the accept edge, so they may change afterwards.
- Store commit occurs exactly at the edge entering RESP. A load issued after a store's response handshake reads the new data.
- Reset asserted mid-WAIT: the pending request is dropped and no write occurs. Reset asserted in RESP: the already-committed write persists and the response is lost.
- Address wrap is never performed. Any index >= DEPTH_WORDS faults, including upper-bit aliases.

## Structure
- Package klp32_mem_pkg holds:
  - the state enum (IDLE/WAIT/RESP);
  - the BE_W=4 and WORD_W=32 constants;
  - a request struct (we, addr, be, wdata), shared with the core-side master.
- Sub-module dmem_array holds the storage: one write port (word index, 4-bit byte-lane mask, data) and one asynchronous read port.
- The FSM, counter, capture registers and fault check live in dmem_responder.

## Test plan
- Reset, LATENCY=2: after reset is released, req_ready=1, rsp_valid=0, rsp_err=0.
- Store 0xDEADBEEF to 0x10 with be=4'hF, then load 0x10 -> rsp_rdata=0xDEADBEEF and err=0. Each rsp_valid appears exactly 2 cycles after acceptance.
- Store 0x000000AA to 0x10 with be=4'b0001 over 0xDEADBEEF, then load -> 0xDEADBEAA.
- Load 0x13 -> err=1, rdata=0. Store to 4*DEPTH_WORDS -> err=1, and a readback of word 0 is unchanged.
- Hold rsp_ready=0 for 5 cycles with req_valid high: rsp_valid and rdata stay stable, req_ready stays 0, and no second request is accepted.
- Assert reset in WAIT of a store of 0x12345678 to 0x20, then release and load 0x20 -> the prior value, with no write committed. Also check that LATENCY=1 gives response valid 1 cycle after acceptance.
